// File: rtl/riscv_pkg.sv
// ============================================================================
// Package : riscv_pkg
// Brief   : Shared defaults, address-width helper and dump FSM encoding.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    function automatic int reg_aw(input int nreg);
        return $clog2(nreg);
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } dump_state_e;

endpackage

`default_nettype wire

// File: rtl/regfile_dump_fsm.sv
// ============================================================================
// Module  : regfile_dump_fsm
// Brief   : Sequences a full register-file readback, one word per accept.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module regfile_dump_fsm
    import riscv_pkg::*;
#(
    parameter int NREG   = NREG_DEF,
    parameter int REG_AW = reg_aw(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dump_start_i,
    input  logic              dump_ready_i,
    output logic              dump_valid_o,
    output logic [REG_AW-1:0] dump_addr_o,
    output logic              dump_busy_o,
    output logic              dump_done_o
);

    localparam logic [REG_AW-1:0] LAST_IDX = REG_AW'(NREG - 1);

    dump_state_e       state_q, state_d;
    logic [REG_AW-1:0] idx_q, idx_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        dump_valid_o = 1'b0;
        dump_busy_o  = 1'b0;
        dump_done_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (dump_start_i) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                dump_valid_o = 1'b1;
                dump_busy_o  = 1'b1;
                if (dump_ready_i) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + REG_AW'(1);
                    end
                end
            end
            DONE: begin
                dump_busy_o = 1'b1;
                dump_done_o = 1'b1;
                state_d     = IDLE;
                // Park the index at 0 so an idle block shows address 0.
                idx_d       = '0;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign dump_addr_o = idx_q;

endmodule

`default_nettype wire

// File: rtl/regfile_dump.sv
// ============================================================================
// Module  : regfile_dump
// Brief   : Two-read/one-write register file (x0 hardwired to zero) with a
//           handshaked full-file dump port. Define REGFILE_BYPASS_EN to
//           forward same-cycle write data onto the read and dump ports.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module regfile_dump
    import riscv_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int REG_AW = reg_aw(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [XLEN-1:0]   rdata1,
    output logic [XLEN-1:0]   rdata2,
    input  logic              dump_start,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [REG_AW-1:0] dump_addr,
    output logic [XLEN-1:0]   dump_data,
    output logic              dump_busy,
    output logic              dump_done
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] w_arr1, w_arr2, w_arrd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign w_arr1 = (raddr1    == '0) ? '0 : regs_q[raddr1];
    assign w_arr2 = (raddr2    == '0) ? '0 : regs_q[raddr2];
    assign w_arrd = (dump_addr == '0) ? '0 : regs_q[dump_addr];

`ifdef REGFILE_BYPASS_EN
    assign rdata1    = (we && (waddr == raddr1)    && (raddr1    != '0)) ? wdata : w_arr1;
    assign rdata2    = (we && (waddr == raddr2)    && (raddr2    != '0)) ? wdata : w_arr2;
    assign dump_data = (we && (waddr == dump_addr) && (dump_addr != '0)) ? wdata : w_arrd;
`else
    assign rdata1    = w_arr1;
    assign rdata2    = w_arr2;
    assign dump_data = w_arrd;
`endif

    regfile_dump_fsm #(
        .NREG   (NREG),
        .REG_AW (REG_AW)
    ) u_fsm (
        .clk          (clk),
        .rst          (rst),
        .dump_start_i (dump_start),
        .dump_ready_i (dump_ready),
        .dump_valid_o (dump_valid),
        .dump_addr_o  (dump_addr),
        .dump_busy_o  (dump_busy),
        .dump_done_o  (dump_done)
    );

endmodule

`default_nettype wire

// File: doc/regfile_dump.md
REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of each register.
REQ-002 SHALL have parameter NREG, default 32, number of registers (power of two); REG_AW = log2(NREG).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port we  input  1  write enable.
REQ-006 SHALL have port waddr  input  REG_AW  write address.
REQ-007 SHALL have port wdata  input  XLEN  write data.
REQ-008 SHALL have ports raddr1/raddr2  input  REG_AW  read addresses.
REQ-009 SHALL have ports rdata1/rdata2  output  XLEN  read data.
REQ-010 SHALL have port dump_start  input  1  request a full-file readback.
REQ-011 SHALL have port dump_valid  output  1  dump word present.
REQ-012 SHALL have port dump_ready  input  1  consumer accepts the dump word.
REQ-013 SHALL have port dump_addr  output  REG_AW  index of the dump word.
REQ-014 SHALL have port dump_data  output  XLEN  content of register dump_addr.
REQ-015 SHALL have port dump_busy  output  1  dump sequence in progress.
REQ-016 SHALL have port dump_done  output  1  one-cycle pulse after the last word is accepted.

Function
REQ-017 SHALL write wdata to register waddr at the rising edge when we=1 and waddr!=0.
REQ-018 SHALL hold register 0 at zero: writes to it are discarded, and reads of it return 0.
REQ-019 SHALL drive rdata1/rdata2 combinationally from the array (zero-cycle read latency).
REQ-020 SHALL implement dump FSM states IDLE, SCAN, DONE.
REQ-021 FSM transitions:
- IDLE -> SCAN on dump_start=1; sets index to 0.
- SCAN -> SCAN on accept when index != NREG-1; index increments.
- SCAN -> DONE on accept when index = NREG-1.
- DONE -> IDLE unconditionally after one cycle.
REQ-022 SHALL define accept as dump_valid && dump_ready; there is one word per accept and at most one accept per cycle.
REQ-023 SHALL assert dump_valid only in SCAN, and SHALL keep dump_addr and dump_data stable while dump_valid=1 and dump_ready=0.
REQ-024 SHALL source dump_data as a combinational read of the array at dump_addr.
- A write to dump_addr during a stall is therefore visible immediately (documented behaviour).
REQ-025 SHALL ignore dump_start while in SCAN or DONE.
REQ-026 SHALL drive dump_busy=1 in SCAN and DONE, and SHALL drive dump_done=1 only in DONE.
REQ-027 SHALL emit exactly NREG accepts per dump, with addresses 0..NREG-1 ascending; the index SHALL NOT wrap past NREG-1.
REQ-028 SHALL keep the normal write and read ports fully functional during a dump.

Reset
REQ-029 On rst=0, asynchronously and at any time including mid-dump, SHALL:
- clear all registers to 0;
- return the FSM to IDLE with index 0;
- drive dump_valid=0, dump_busy=0, dump_done=0, dump_addr=0, dump_data=0, rdata1=0, rdata2=0.
REQ-030 SHALL NOT resume an interrupted dump after reset is released.

Configuration
REQ-031 Macro REGFILE_BYPASS_EN, when defined, SHALL forward wdata to rdata1/rdata2 and dump_data in the same cycle when we=1, the write address matches the read address, and the address is nonzero.
REQ-032 Without REGFILE_BYPASS_EN, reads SHALL return the pre-write value until the next cycle.

Structure
REQ-033 Package riscv_pkg SHALL hold:
- XLEN and NREG defaults;
- the REG_AW derivation;
- the dump FSM state enum (IDLE/SCAN/DONE).
REQ-034 The dump FSM and index counter SHALL be the sub-module regfile_dump_fsm; the array and ports SHALL live in regfile_dump.

Verification
REQ-035 Reset, then read all registers -> all 0; write x0=0xFFFFFFFF, read x0 -> 0.
REQ-036 Write x5=0x12345678, then read raddr1=5 next cycle -> 0x12345678.
- With REGFILE_BYPASS_EN: same-cycle read -> 0x12345678.
- Without it: same-cycle read -> 0.
REQ-037 Load xi=i*0x11 for i=1..31, pulse dump_start, hold dump_ready=1 ->
- 32 consecutive words with addr 0..31 and data 0, 0x11, ..., 0x20F;
- dump_done pulses once, one cycle after the last accept;
- dump_busy is low afterwards.
REQ-038 Dump with dump_ready toggling every other cycle -> dump_addr/dump_data stable during stalls; exactly 32 accepts; no address skipped or repeated.
REQ-039 Pulse dump_start again at address 10 mid-dump -> ignored; sequence continues from 11; a single dump_done.
REQ-040 Assert rst=0 at dump address 7 -> dump_valid=0 and dump_busy=0 immediately, registers read 0, and no dump resumes after release.
